// File: rtl/core_pkg.sv
// Shared constants and types for the RV32I multi-cycle control sequencer.
package core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_BR    = 2'b01;
    localparam logic [1:0] PC_SEL_JALR  = 2'b10;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_BRANCH  = 3'd1,
        CLS_JAL     = 3'd2,
        CLS_JALR    = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_SYSTEM  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } cls_e;

endpackage

// File: rtl/ctrl_classify.sv
// Combinational opcode/funct3 classifier; unsupported encodings map to CLS_ILLEGAL.
module ctrl_classify
    import core_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output cls_e       cls,
    output logic       imm_b
);

    always_comb begin
        cls   = CLS_ILLEGAL;
        imm_b = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_OP: cls = CLS_ALU;
            OP_IMM: begin
                cls   = CLS_ALU;
                imm_b = 1'b1;
            end
            OP_JAL: cls = CLS_JAL;
            OP_JALR: begin
                imm_b = 1'b1;
                if (funct3 == 3'b000) cls = CLS_JALR;
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) cls = CLS_BRANCH;
            end
            OP_LOAD: begin
                imm_b = 1'b1;
                if (funct3 != 3'b011 && funct3[2:1] != 2'b11) cls = CLS_LOAD;
            end
            OP_STORE: begin
                imm_b = 1'b1;
                if (funct3 <= 3'b010) cls = CLS_STORE;
            end
            OP_SYSTEM: cls = CLS_SYSTEM;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core.
// Optional cycle/instret counters are built only when CORE_CTRL_CNT_EN is defined.
module core_ctrl
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic        busy,
    output logic        illegal
`ifdef CORE_CTRL_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    state_e state_q, state_d;
    cls_e   cls_q, cls_d, dec_cls;
    logic   imm_q, imm_d, dec_imm;
    logic   illegal_q, illegal_d;

    ctrl_classify u_classify (
        .opcode (opcode),
        .funct3 (funct3),
        .cls    (dec_cls),
        .imm_b  (dec_imm)
    );

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        alu_src_b = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                imm_d = dec_imm;
                if (dec_cls == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (dec_cls == CLS_SYSTEM) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_b = imm_q;
                case (cls_q)
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_SEL_BR : PC_SEL_PLUS4;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        rf_we   = 1'b1;
                        wb_sel  = WB_SEL_PC4;
                        pc_we   = 1'b1;
                        pc_sel  = (cls_q == CLS_JAL) ? PC_SEL_BR : PC_SEL_JALR;
                        state_d = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // operand B held so the ALU keeps driving the address
                alu_src_b = imm_q;
                dmem_req  = 1'b1;
                dmem_we   = (cls_q == CLS_STORE);
                if (dmem_ack) begin
                    if (cls_q == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                alu_src_b = imm_q;
                rf_we     = 1'b1;
                wb_sel    = (cls_q == CLS_LOAD) ? WB_SEL_MEM : WB_SEL_ALU;
                pc_we     = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_ALU;
            imm_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign illegal = illegal_q;

`ifdef CORE_CTRL_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    // every retire path is marked by the single pc_we pulse
    always_comb begin
        cycle_d   = busy  ? cycle_q + 32'd1   : cycle_q;
        instret_d = pc_we ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule
